// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage
//   Execute stage and EX/MEM pipeline register. Computes logic, shift and
//   move results from the decoded bundle, owns the architectural HI/LO
//   registers and runs a 32-iteration shift-add multiplier for MULT/MULTU,
//   holding the pipeline via stallreq_o while the multiply is in flight.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   aluop_i           operation subtype (EXE_*_OP)
//   alusel_i          operation class (EXE_RES_*)
//   reg1_i, reg2_i    source operands
//   wd_i, wreg_i      destination address / write enable from decode
//   wd_o, wreg_o,     registered destination, write enable and result
//   wdata_o             toward the memory stage
//   hi_o, lo_o        current HI / LO register contents
//   stallreq_o        combinational stall request to pipeline control
module ex_muldiv_stage #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  // Operation subtypes
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;

  // Operation classes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  localparam int CNT_W = $clog2(MUL_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mul_state_t;

  mul_state_t            state_reg;
  logic [DATA_W-1:0]     hi_reg;
  logic [DATA_W-1:0]     lo_reg;
  logic [2*DATA_W-1:0]   acc_reg;
  logic [2*DATA_W-1:0]   mcand_reg;
  logic [DATA_W-1:0]     mplier_reg;
  logic                  sign_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic                  is_mul;
  logic                  is_signed_mul;
  logic                  stall;
  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;
  logic [DATA_W-1:0]     result;

  assign is_mul        = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign is_signed_mul = (aluop_i == EXE_MULT_OP);

  // Stall covers the presentation cycle plus every BUSY cycle; DONE releases
  // the pipeline so the held multiply is consumed at the DONE edge.
  assign stall      = ((state_reg == ST_IDLE) && is_mul) || (state_reg == ST_BUSY);
  assign stallreq_o = !rst && stall;

  // Magnitudes for the unsigned core; 0x80000000 negates to itself, which is
  // exactly 2^31 when read as unsigned, so no special case is needed.
  assign op1_abs = (is_signed_mul && reg1_i[DATA_W-1]) ? ('0 - reg1_i) : reg1_i;
  assign op2_abs = (is_signed_mul && reg2_i[DATA_W-1]) ? ('0 - reg2_i) : reg2_i;

  always_comb begin
    result = '0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP: result = $signed(reg2_i) >>> reg1_i[4:0];
          default:    result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: result = hi_reg;
          EXE_MFLO_OP: result = lo_reg;
          EXE_MOVN_OP,
          EXE_MOVZ_OP: result = reg1_i;
          default:     result = '0;
        endcase
      end
      EXE_RES_NOP: result = '0;
      default:     result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      hi_reg     <= '0;
      lo_reg     <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      sign_reg   <= 1'b0;
      cnt_reg    <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (is_mul) begin
            mcand_reg  <= {{DATA_W{1'b0}}, op1_abs};
            mplier_reg <= op2_abs;
            sign_reg   <= is_signed_mul && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= ST_BUSY;
          end else if (aluop_i == EXE_MTHI_OP) begin
            hi_reg <= reg1_i;
          end else if (aluop_i == EXE_MTLO_OP) begin
            lo_reg <= reg1_i;
          end
        end
        ST_BUSY: begin
          if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
          end
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          {hi_reg, lo_reg} <= sign_reg ? ('0 - acc_reg) : acc_reg;
          state_reg        <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Stall and DONE cycles carry no GPR write: push a bubble to MEM.
      if (stall || (state_reg == ST_DONE)) begin
        wd_o    <= '0;
        wreg_o  <= 1'b0;
        wdata_o <= '0;
      end else begin
        wd_o    <= wd_i;
        wreg_o  <= wreg_i && (aluop_i != EXE_MTHI_OP) && (aluop_i != EXE_MTLO_OP);
        wdata_o <= result;
      end
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Testbench for ex_muldiv_stage: directed cases followed by randomized
// instructions. The stimulus process drives one cycle at a time and pushes
// the expected per-cycle observation into a queue; a monitor process pops
// and compares on every falling edge.
module tb_ex_muldiv_stage;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_BAD   = 3'b111;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  ex_muldiv_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One observation per cycle: the stall request for this cycle and the
  // registered state left by the previous edge.
  typedef struct {
    bit          chk_out;
    bit          stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model state
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          m_valid = 1'b0;
  int          m_mul_age = 0;    // 0: no multiply in flight, else cycles since presentation
  logic [63:0] m_prod;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [2:0] sel,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] r;
    r = 32'h0;
    if (sel == SEL_LOGIC) begin
      if (op == OP_OR)  r = a | b;
      if (op == OP_AND) r = a & b;
      if (op == OP_XOR) r = a ^ b;
      if (op == OP_NOR) r = ~(a | b);
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) r = b << a[4:0];
      if (op == OP_SRL) r = b >> a[4:0];
      if (op == OP_SRA) r = $signed(b) >>> a[4:0];
    end else if (sel == SEL_MOVE) begin
      if (op == OP_MFHI) r = hi;
      if (op == OP_MFLO) r = lo;
      if (op == OP_MOVN || op == OP_MOVZ) r = a;
    end
    return r;
  endfunction

  // Drive one cycle, record what should be observed in it, advance the model
  // across the closing edge.
  task automatic step(input bit r, input logic [7:0] op, input logic [2:0] sel,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] wd, input logic wreg);
    exp_t e;
    bit   is_mul;
    bit   st;
    logic [31:0] res;
    rst      = r;
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wreg;

    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    st = !r && ((m_mul_age == 0 && is_mul) || (m_mul_age >= 1 && m_mul_age <= 32));
    e.chk_out = m_valid;
    e.stall   = st;
    e.wd      = m_wd;
    e.wreg    = m_wreg;
    e.wdata   = m_wdata;
    e.hi      = m_hi;
    e.lo      = m_lo;
    exp_q.push_back(e);

    if (r) begin
      m_wd = 0; m_wreg = 0; m_wdata = 0; m_hi = 0; m_lo = 0; m_mul_age = 0;
    end else if (m_mul_age == 0 && is_mul) begin
      if (op == OP_MULT) m_prod = 64'(longint'($signed(a)) * longint'($signed(b)));
      else               m_prod = {32'h0, a} * {32'h0, b};
      m_wd = 0; m_wreg = 0; m_wdata = 0;
      m_mul_age = 1;
    end else if (m_mul_age >= 1 && m_mul_age <= 32) begin
      m_wd = 0; m_wreg = 0; m_wdata = 0;
      m_mul_age++;
    end else if (m_mul_age == 33) begin
      {m_hi, m_lo} = m_prod;
      m_wd = 0; m_wreg = 0; m_wdata = 0;
      m_mul_age = 0;
    end else begin
      res     = ref_result(op, sel, a, b, m_hi, m_lo);
      m_wd    = wd;
      m_wreg  = wreg && (op != OP_MTHI) && (op != OP_MTLO);
      m_wdata = res;
      if (op == OP_MTHI) m_hi = a;
      if (op == OP_MTLO) m_lo = a;
    end
    m_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and hold it until the stage consumes it.
  task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wreg);
    $display("issue op=%h sel=%0d a=%h b=%h wd=%0d wreg=%0d", op, sel, a, b, wd, wreg);
    step(1'b0, op, sel, a, b, wd, wreg);
    for (int k = 0; k < 40 && m_mul_age != 0; k++) begin
      step(1'b0, op, sel, a, b, wd, wreg);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    int unsigned k;
    k = $urandom_range(0, 7);
    if (k == 5) return 32'h0;
    if (k == 6) return 32'h8000_0000;
    if (k == 7) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  task automatic rnd_instr(output logic [7:0] op, output logic [2:0] sel);
    int unsigned k;
    k = $urandom_range(0, 16);
    case (k)
      0:  begin op = OP_OR;    sel = SEL_LOGIC; end
      1:  begin op = OP_AND;   sel = SEL_LOGIC; end
      2:  begin op = OP_XOR;   sel = SEL_LOGIC; end
      3:  begin op = OP_NOR;   sel = SEL_LOGIC; end
      4:  begin op = OP_SLL;   sel = SEL_SHIFT; end
      5:  begin op = OP_SRL;   sel = SEL_SHIFT; end
      6:  begin op = OP_SRA;   sel = SEL_SHIFT; end
      7:  begin op = OP_MFHI;  sel = SEL_MOVE;  end
      8:  begin op = OP_MFLO;  sel = SEL_MOVE;  end
      9:  begin op = OP_MOVN;  sel = SEL_MOVE;  end
      10: begin op = OP_MOVZ;  sel = SEL_MOVE;  end
      11: begin op = OP_MTHI;  sel = SEL_NOP;   end
      12: begin op = OP_MTLO;  sel = SEL_NOP;   end
      13: begin op = OP_MULT;  sel = SEL_NOP;   end
      14: begin op = OP_MULTU; sel = SEL_NOP;   end
      15: begin op = OP_OR;    sel = SEL_BAD;   end
      default: begin op = OP_NOP; sel = SEL_NOP; end
    endcase
  endtask

  // Monitor: compare every recorded observation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stallreq", 64'(stallreq_o), 64'(e.stall));
        if (e.chk_out) begin
          chk("wd_o",    64'(wd_o),    64'(e.wd));
          chk("wreg_o",  64'(wreg_o),  64'(e.wreg));
          chk("wdata_o", 64'(wdata_o), 64'(e.wdata));
          chk("hi_o",    64'(hi_o),    64'(e.hi));
          chk("lo_o",    64'(lo_o),    64'(e.lo));
        end
      end
    end
  end

  initial begin
    logic [7:0] op;
    logic [2:0] sel;
    rst = 1'b1; aluop_i = OP_NOP; alusel_i = SEL_NOP;
    reg1_i = 0; reg2_i = 0; wd_i = 0; wreg_i = 0;
    @(posedge clk);
    #1;
    step(1'b1, OP_NOP, SEL_NOP, 0, 0, 0, 0);
    step(1'b1, OP_NOP, SEL_NOP, 0, 0, 0, 0);

    // Logic and shifts
    issue(OP_OR,  SEL_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F, 5'd3, 1'b1);
    issue(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd6, 1'b1);
    issue(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd7, 1'b1);

    // MTHI then MFHI back to back; LO stays untouched
    issue(OP_MTHI, SEL_NOP,  32'h1234_5678, 32'h0, 5'd9, 1'b1);
    issue(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd5, 1'b1);
    issue(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd8, 1'b1);

    // Multiplies, with MFHI/MFLO right after DONE
    issue(OP_MULT,  SEL_NOP,  32'hFFFF_FFFE, 32'd3, 5'd1, 1'b1);
    issue(OP_MFHI,  SEL_MOVE, 32'h0, 32'h0, 5'd10, 1'b1);
    issue(OP_MFLO,  SEL_MOVE, 32'h0, 32'h0, 5'd11, 1'b1);
    issue(OP_MULTU, SEL_NOP,  32'hFFFF_FFFE, 32'd3, 5'd1, 1'b1);
    issue(OP_MFHI,  SEL_MOVE, 32'h0, 32'h0, 5'd12, 1'b1);
    issue(OP_MULT,  SEL_NOP,  32'h8000_0000, 32'h8000_0000, 5'd2, 1'b1);
    issue(OP_MFLO,  SEL_MOVE, 32'h0, 32'h0, 5'd13, 1'b1);
    issue(OP_MULT,  SEL_NOP,  32'h0, 32'hFFFF_FFFF, 5'd2, 1'b1);

    // Reset in the middle of a multiply, then a fresh multiply
    $display("issue mult aborted by reset");
    for (int k = 0; k < 10; k++) step(1'b0, OP_MULT, SEL_NOP, 32'hFFFF_FFFF, 32'd9, 5'd4, 1'b1);
    step(1'b1, OP_MULT, SEL_NOP, 32'hFFFF_FFFF, 32'd9, 5'd4, 1'b1);
    issue(OP_NOP,  SEL_NOP,  32'h0, 32'h0, 5'd0, 1'b0);
    issue(OP_MULT, SEL_NOP,  32'd5, 32'd7, 5'd4, 1'b1);
    issue(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd14, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      rnd_instr(op, sel);
      issue(op, sel, rnd_operand(), rnd_operand(), 5'($urandom), 1'($urandom));
    end
    issue(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Execute stage that consumes the decoded bundle from the decode stage: aluop, alusel, two source operands, destination and write-enable.
- Computes logic, shift and move results and owns the architectural HI/LO registers.
- Runs a 32-iteration sequential multiplier for mult/multu and stalls upstream while it is busy.
- Result is registered into the EX/MEM boundary, so this block is also the pipeline register toward the memory stage.

Parameters:
- DATA_W, 32, operand/result width (only 32 supported)
- MUL_ITER, 32, multiplier iterations (must equal DATA_W)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  operation subtype (EXE_*_OP); adds EXE_MULT_OP, EXE_MULTU_OP to defines
- alusel_i  in  3  operation class (EXE_RES_*)
- reg1_i  in  32  source operand 1 (rs or immediate)
- reg2_i  in  32  source operand 2 (rt or immediate)
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- wd_o  out  5  registered destination address to MEM
- wreg_o  out  1  registered write enable to MEM
- wdata_o  out  32  registered result to MEM
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register
- stallreq_o  out  1  combinational stall request to pipeline control

Behaviour:
- Reset (rst=1 at edge):
  - wd_o=0, wreg_o=0, wdata_o=0, HI=0, LO=0, FSM=IDLE, counter=0.
  - stallreq_o=0 while rst=1.
  - Reset mid-multiply aborts it; HI/LO are not updated.
- Combinational result by alusel_i:
  - LOGIC: OR/AND/XOR/NOR of reg1_i, reg2_i.
  - SHIFT: SLL/SRL/SRA of reg2_i by reg1_i[4:0]; SRA sign-fills.
  - MOVE: MFHI→HI, MFLO→LO, MOVN/MOVZ→reg1_i. wreg for MOVN/MOVZ is taken as supplied by decode.
  - NOP or unknown: 0.
- Output register, non-stall cycle: wd_o<=wd_i, wreg_o<=wreg_i, wdata_o<=result. One-cycle latency.
- Output register, stall cycle: bubble, i.e. wreg_o<=0, wd_o<=0, wdata_o<=0.
- MTHI/MTLO: on a non-stall edge HI (resp. LO) <= reg1_i; the other half is unchanged. wreg is forced 0 regardless of wreg_i.
- MFHI/MFLO issued in the cycle after MTHI/MTLO or after a multiply DONE read the new value; HI/LO are written at that edge, so no hazard exists.
- Multiplier FSM:
  - IDLE:
    - aluop_i=MULT/MULTU → stallreq_o=1 (combinational).
    - Latch |reg1_i| and |reg2_i| (raw values for MULTU) and the sign flag (reg1_i[31]^reg2_i[31], MULT only). Clear the 64-bit accumulator and counter, go BUSY.
  - BUSY:
    - stallreq_o=1.
    - Each cycle: if multiplier bit0 set, acc += multiplicand shifted; shift. counter++.
    - After MUL_ITER iterations go DONE.
    - Inputs are ignored; upstream holds them stable.
  - DONE:
    - stallreq_o=0.
    - {HI,LO} <= sign ? -acc : acc. Output register takes a bubble (mult writes no GPR).
    - Next state IDLE; the held mult instruction is consumed at this edge.
  - Timing: total 33 stall cycles, 34 cycles from mult presentation to next instruction acceptance.
- Signed edge cases:
  - 0x80000000 × 0x80000000 (MULT) = 0x40000000_00000000.
  - Any operand 0 → 0 with sign ignored.
- Only one operation per cycle; no simultaneous HI/LO writers are possible.

Test Plan:
- ORI-style: aluop=OR, reg1=0x0000_F0F0, reg2=0x0000_0F0F, wd=3, wreg=1 → next edge wdata_o=0x0000_FFFF, wd_o=3, wreg_o=1.
- SRA: reg1=4, reg2=0x8000_0010 → wdata_o=0xF800_0001; SRL same operands → 0x0800_0001.
- MTHI 0x1234_5678 then MFHI wd=5 next cycle → wdata_o=0x1234_5678, wreg_o=1; LO unchanged; MTHI cycle wreg_o=0.
- MULT reg1=0xFFFF_FFFE (-2), reg2=3 → stallreq_o high exactly 33 cycles, wreg_o=0 throughout; then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. MULTU same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- MULT 0x8000_0000 × 0x8000_0000 → HI=0x4000_0000, LO=0; the following MFLO returns 0.
- rst asserted at BUSY cycle 10 → next cycle stallreq_o=0, HI=LO=0, outputs 0; a fresh MULT 5×7 then yields LO=35, HI=0.
